mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpustate  in  2  mode select: 00 idle, 01 load, 10 run, 11 reserved (treated as idle).
- addr  in  16  CPU address.
- din  in  8  CPU write data, taken from the CPU data_out.
- read  in  1  CPU read strobe.
- write  in  1  CPU write strobe.
- ld_valid  in  1  loader byte-valid strobe, one byte per high cycle.
- ld_data  in  8  loader byte.
- dout  out  8  read data to the CPU data_in.
- ld_addr  out  8  next loader write address.
- ld_full  out  1  loader has filled all 256 locations.
- addr_err  out  1  sticky flag: out-of-range CPU access.
- par_err  out  1  sticky flag: parity mismatch on read (only with MEM_PARITY_EN).

Function
REQ-002 SHALL contain a 256 x 8 storage array, indexed by addr[7:0].
REQ-003 SHALL implement a mode FSM with states IDLE, LOAD and RUN, registered from cpustate on every clk edge; 11 maps to IDLE.
REQ-004 On any transition into LOAD, ld_addr SHALL clear to 0 and ld_full SHALL clear to 0 in the same edge.
REQ-005 In LOAD with ld_valid=1 and ld_full=0:
- ld_data SHALL be written to array[ld_addr];
- ld_addr SHALL increment by 1, modulo 256.
REQ-006 When a LOAD write occurs at ld_addr=255, ld_addr SHALL wrap to 0 and ld_full SHALL set; while ld_full=1, further ld_valid SHALL be ignored.
REQ-007 In LOAD, CPU read and write strobes SHALL be ignored; dout SHALL be 8'h00.
REQ-008 In RUN, write=1 with addr[15:8]=0 SHALL write din to array[addr[7:0]] at the clk edge.
REQ-009 In RUN, read=1 with addr[15:8]=0 SHALL drive dout combinationally to array[addr[7:0]], with zero-cycle latency (valid in the same cycle).
REQ-010 In RUN, a read or write with addr[15:8]!=0:
- SHALL NOT modify the array;
- SHALL return dout=8'h00;
- SHALL set addr_err, which stays set until reset.
REQ-011 read=1 and write=1 in the same RUN cycle SHALL perform the write; dout SHALL show the pre-write contents.
REQ-012 dout SHALL be 8'h00 whenever read=0 or the state is not RUN.
REQ-013 In IDLE, the array, ld_addr and ld_full SHALL hold; ld_valid, read and write SHALL be ignored.
REQ-014 Leaving LOAD SHALL retain ld_addr and ld_full until the next entry into LOAD.

Reset
REQ-015 On rst=0, asynchronously:
- state SHALL go to IDLE;
- ld_addr, ld_full, addr_err and par_err SHALL go to 0;
- dout SHALL go to 8'h00.
REQ-016 Array contents SHALL NOT be cleared by reset.
REQ-017 Reset asserted mid-load SHALL abort the load. After release, loading SHALL restart at address 0 on the next LOAD entry, and previously written bytes SHALL remain in the array.

Configuration
REQ-018 Macro MEM_PARITY_EN defined:
- each location SHALL store a 9th bit, the even parity of the byte written (loader or CPU);
- a RUN read whose stored parity mismatches SHALL set the sticky par_err;
- dout SHALL still return the stored byte.
REQ-019 Macro MEM_PARITY_EN undefined:
- no parity storage;
- par_err SHALL be tied to 0.

Verification
REQ-020 Reset, then LOAD with 4 ld_valid bytes 3E,05,11,FF -> array[0..3]=3E,05,11,FF; ld_addr=4; ld_full=0.
REQ-021 LOAD with 256 consecutive ld_valid bytes, then one more byte AA -> ld_full=1, ld_addr=0, array[0] unchanged (not AA).
REQ-022 RUN, write=1, addr=0x0010, din=5A, then read=1 at 0x0010 -> dout=5A in the read cycle; read=0 -> dout=00.
REQ-023 RUN, write=1, addr=0x0123, din=77 -> array[0x23] unchanged, addr_err=1 and stays 1 after further legal accesses until rst=0.
REQ-024 LOAD of 2 bytes, rst pulsed low mid-cycle, then LOAD re-entered and byte C3 sent -> array[0]=C3, array[1] retains its earlier byte, ld_addr=1.
REQ-025 With MEM_PARITY_EN: force a stored parity bit to flip at location 0x05, then RUN read of 0x05 -> dout=stored byte, par_err=1; without the macro, par_err=0 throughout.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: 256 x 8 memory with a byte-stream loader and a CPU access port.
//
// Modes are taken from cpustate and registered on every clk edge:
//   00 idle, 01 load, 10 run, 11 treated as idle.
// Load mode streams ld_data into consecutive locations starting at 0.
// Run mode gives the CPU synchronous writes and zero-latency combinational reads.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cpustate[1:0]   mode select
//   addr[15:0]      CPU address (only 0x0000-0x00FF is in range)
//   din[7:0]        CPU write data
//   read, write     CPU strobes
//   ld_valid        loader byte strobe
//   ld_data[7:0]    loader byte
//   dout[7:0]       CPU read data (00 unless a valid run-mode read)
//   ld_addr[7:0]    next loader write address
//   ld_full         all 256 locations loaded
//   addr_err        sticky out-of-range CPU access flag
//   par_err         sticky parity mismatch flag
//
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per
// location and check it on run-mode reads. Without it par_err is tied to 0.
// The array itself is never reset.

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cpustate,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        read,
  input  logic        write,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic [7:0]  dout,
  output logic [7:0]  ld_addr,
  output logic        ld_full,
  output logic        addr_err,
  output logic        par_err
);

`ifdef MEM_PARITY_EN
  localparam int unsigned MemW = 9;
`else
  localparam int unsigned MemW = 8;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e state_q, state_d;

  logic [MemW-1:0] mem [256];
  logic [MemW-1:0] rd_word;
  logic [MemW-1:0] wr_word;
  logic [7:0]      wr_idx;
  logic [7:0]      wr_byte;
  logic            in_range;
  logic            ld_we;
  logic            cpu_we;
  logic            cpu_rd;
  logic            cpu_oob;

  always_comb begin
    state_d = StIdle;
    case (cpustate)
      2'b01:   state_d = StLoad;
      2'b10:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  assign in_range = (addr[15:8] == 8'h00);
  assign ld_we    = (state_q == StLoad) && ld_valid && !ld_full;
  assign cpu_we   = (state_q == StRun) && write && in_range;
  assign cpu_rd   = (state_q == StRun) && read && in_range;
  assign cpu_oob  = (state_q == StRun) && (read || write) && !in_range;

  // Loader and CPU writes are mutually exclusive by mode.
  assign wr_idx  = ld_we ? ld_addr : addr[7:0];
  assign wr_byte = ld_we ? ld_data : din;

`ifdef MEM_PARITY_EN
  assign wr_word = {^wr_byte, wr_byte};
`else
  assign wr_word = wr_byte;
`endif

  always_ff @(posedge clk) begin
    if (ld_we || cpu_we) begin
      mem[wr_idx] <= wr_word;
    end
  end

  // Read data is the pre-write contents when read and write coincide.
  assign rd_word = mem[addr[7:0]];
  assign dout    = cpu_rd ? rd_word[7:0] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ld_addr  <= 8'h00;
      ld_full  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StLoad && state_q != StLoad) begin
        ld_addr <= 8'h00;
        ld_full <= 1'b0;
      end else if (ld_we) begin
        ld_addr <= ld_addr + 8'd1;
        if (ld_addr == 8'hFF) begin
          ld_full <= 1'b1;
        end
      end
      if (cpu_oob) begin
        addr_err <= 1'b1;
      end
    end
  end

`ifdef MEM_PARITY_EN
  // Even parity: a good 9-bit word XORs to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
    end else if (cpu_rd && (^rd_word)) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Stimulus pushes expected values
// into a queue; a monitor pops and compares them on the falling edge of each
// observation cycle.

module tb_mem_ctrl;

  localparam int SelDout  = 0;
  localparam int SelLdAdr = 1;
  localparam int SelFull  = 2;
  localparam int SelAErr  = 3;
  localparam int SelPErr  = 4;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cpustate;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        read;
  logic        write;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic [7:0]  dout;
  logic [7:0]  ld_addr;
  logic        ld_full;
  logic        addr_err;
  logic        par_err;

  exp_t q[$];
  logic obs = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cpustate (cpustate),
    .addr     (addr),
    .din      (din),
    .read     (read),
    .write    (write),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .dout     (dout),
    .ld_addr  (ld_addr),
    .ld_full  (ld_full),
    .addr_err (addr_err),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  // Monitor: drains every expectation queued for the current observation cycle.
  always @(negedge clk) begin
    if (obs) begin
      while (q.size() != 0) begin
        exp_t       e;
        logic [7:0] act;
        e = q.pop_front();
        case (e.sel)
          SelDout:  act = dout;
          SelLdAdr: act = ld_addr;
          SelFull:  act = {7'b0, ld_full};
          SelAErr:  act = {7'b0, addr_err};
          default:  act = {7'b0, par_err};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic push(input string name, input int sel, input logic [7:0] e);
    q.push_back('{name, sel, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    obs = 1'b1;
    tick();
    obs = 1'b0;
  endtask

  // After this returns the registered mode equals m.
  task automatic set_mode(input logic [1:0] m);
    cpustate = m;
    tick();
  endtask

  task automatic load_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr  = a;
    din   = d;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic run_read(input logic [15:0] a, input logic [7:0] e, input string name);
    addr = a;
    read = 1'b1;
    push(name, SelDout, e);
    observe();
    read = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cpustate = 2'b00; addr = '0; din = '0;
    read = 1'b0; write = 1'b0; ld_valid = 1'b0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, observed while reset is held
    push("rst_dout", SelDout, 8'h00);
    push("rst_ld_addr", SelLdAdr, 8'h00);
    push("rst_ld_full", SelFull, 8'h00);
    push("rst_addr_err", SelAErr, 8'h00);
    push("rst_par_err", SelPErr, 8'h00);
    observe();
    rst = 1'b1;
    tick();

    // Short load of four bytes
    set_mode(2'b01);
    load_byte(8'h3E); load_byte(8'h05); load_byte(8'h11); load_byte(8'hFF);
    addr = 16'h0000; read = 1'b1;
    push("load4_ld_addr", SelLdAdr, 8'h04);
    push("load4_ld_full", SelFull, 8'h00);
    push("load_read_ignored", SelDout, 8'h00);
    observe();
    read = 1'b0;
    set_mode(2'b10);
    run_read(16'h0000, 8'h3E, "load4_m0");
    run_read(16'h0001, 8'h05, "load4_m1");
    run_read(16'h0002, 8'h11, "load4_m2");
    run_read(16'h0003, 8'hFF, "load4_m3");
    push("run_keeps_ld_addr", SelLdAdr, 8'h04);
    observe();

    // Full load of 256 bytes (i ^ 5A), then one ignored extra byte
    set_mode(2'b00);
    set_mode(2'b01);
    push("reentry_ld_addr", SelLdAdr, 8'h00);
    observe();
    for (int i = 0; i < 255; i++) load_byte(8'(i) ^ 8'h5A);
    push("ld255_ld_addr", SelLdAdr, 8'hFF);
    push("ld255_ld_full", SelFull, 8'h00);
    observe();
    load_byte(8'hA5);
    push("ld256_ld_addr", SelLdAdr, 8'h00);
    push("ld256_ld_full", SelFull, 8'h01);
    observe();
    load_byte(8'hAA);
    push("extra_ld_addr", SelLdAdr, 8'h00);
    push("extra_ld_full", SelFull, 8'h01);
    observe();
    set_mode(2'b10);
    run_read(16'h0000, 8'h5A, "full_m0_not_aa");
    run_read(16'h00FF, 8'hA5, "full_mff");

    // CPU write/read, read low, read+write together
    cpu_write(16'h0010, 8'h5A);
    run_read(16'h0010, 8'h5A, "cpu_wr_rd");
    addr = 16'h0010;
    push("read_low_dout", SelDout, 8'h00);
    observe();
    din = 8'h99; write = 1'b1; read = 1'b1;
    push("rw_prewrite", SelDout, 8'h5A);
    observe();
    write = 1'b0; read = 1'b0;
    run_read(16'h0010, 8'h99, "rw_postwrite");
    push("no_addr_err_yet", SelAErr, 8'h00);
    observe();

    // Idle and reserved mode ignore all strobes
    set_mode(2'b00);
    cpu_write(16'h0010, 8'h11);
    load_byte(8'h33);
    run_read(16'h0010, 8'h00, "idle_dout");
    set_mode(2'b11);
    cpu_write(16'h0010, 8'h22);
    run_read(16'h0010, 8'h00, "rsvd_dout");
    set_mode(2'b10);
    run_read(16'h0010, 8'h99, "idle_no_write");
    push("idle_ld_addr", SelLdAdr, 8'h00);
    push("idle_ld_full", SelFull, 8'h01);
    observe();

    // Out-of-range access is sticky and harmless
    cpu_write(16'h0123, 8'h77);
    push("oob_addr_err", SelAErr, 8'h01);
    observe();
    run_read(16'h0023, 8'h79, "oob_no_write");
    run_read(16'h0123, 8'h00, "oob_read_dout");
    cpu_write(16'h0040, 8'h12);
    run_read(16'h0040, 8'h12, "legal_after_oob");
    push("addr_err_sticky", SelAErr, 8'h01);
    observe();

`ifdef MEM_PARITY_EN
    dut.mem[5][8] = ~dut.mem[5][8];
    run_read(16'h0005, 8'h5F, "par_dout");
    push("par_err_set", SelPErr, 8'h01);
    observe();
`else
    run_read(16'h0005, 8'h5F, "nopar_dout");
    push("par_err_tied", SelPErr, 8'h00);
    observe();
`endif

    // Reset in the middle of a load
    set_mode(2'b00);
    set_mode(2'b01);
    load_byte(8'h11);
    load_byte(8'h22);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    push("midrst_ld_addr", SelLdAdr, 8'h00);
    push("midrst_ld_full", SelFull, 8'h00);
    push("midrst_addr_err", SelAErr, 8'h00);
    push("midrst_par_err", SelPErr, 8'h00);
    observe();
    load_byte(8'hC3);
    push("reload_ld_addr", SelLdAdr, 8'h01);
    observe();
    set_mode(2'b10);
    run_read(16'h0000, 8'hC3, "reload_m0");
    run_read(16'h0001, 8'h22, "reload_m1_kept");
    run_read(16'h0002, 8'h58, "reload_m2_kept");

    repeat (2) tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
